// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and load/store requesters onto one handshaked memory port.
// Data has priority; fetch gets a forced grant after STARVE_LIMIT back-to-back data grants.
module mem_arbiter #(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_imem_req,
    input  logic [31:0] i_imem_addr,
    output logic        o_imem_ready,
    output logic        o_imem_valid,
    output logic [31:0] o_imem_rdata,
    output logic        o_imem_err,
    input  logic        i_dmem_req,
    input  logic [31:0] i_dmem_addr,
    input  logic        i_dmem_wen,
    input  logic [31:0] i_dmem_wdata,
    input  logic [3:0]  i_dmem_mask,
    output logic        o_dmem_ready,
    output logic        o_dmem_valid,
    output logic [31:0] o_dmem_rdata,
    output logic        o_dmem_err,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_ready,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_rdata
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t        r_state, w_next;
    logic [SW-1:0] r_starve;
    logic [TW-1:0] r_tcnt;
    logic          r_owner_d, r_wen, r_err;
    logic [31:0]   r_addr, r_wdata, r_rdata;
    logic [3:0]    r_mask;

    logic          w_starved, w_grant_i, w_grant_d, w_grant, w_timeout;
    logic [31:0]   w_req_addr;

    assign w_starved  = (r_starve == STARVE_MAX);
    assign w_grant_i  = (r_state == S_IDLE) && i_imem_req && (!i_dmem_req || w_starved);
    assign w_grant_d  = (r_state == S_IDLE) && i_dmem_req && !w_grant_i;
    assign w_grant    = w_grant_i || w_grant_d;
    assign w_timeout  = (r_tcnt == TCNT_LAST);
    assign w_req_addr = w_grant_d ? i_dmem_addr : i_imem_addr;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // A response in the last allowed WAIT cycle beats the timeout.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_next = S_ISSUE;
            S_ISSUE: if (w_timeout) w_next = S_RESP;
                     else if (i_mem_ready) w_next = S_WAIT;
            S_WAIT:  if (i_mem_valid || w_timeout) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_owner_d <= 1'b0;
            r_addr    <= '0;
            r_wen     <= 1'b0;
            r_wdata   <= '0;
            r_mask    <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_tcnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_grant) begin
                    r_owner_d <= w_grant_d;
                    r_addr    <= w_req_addr & 32'hFFFF_FFFC;
                    r_wen     <= w_grant_d & i_dmem_wen;
                    r_wdata   <= w_grant_d ? i_dmem_wdata : 32'h0;
                    r_mask    <= w_grant_d ? i_dmem_mask : 4'hF;
                    r_rdata   <= '0;
                    r_err     <= 1'b0;
                    r_tcnt    <= '0;
                end
                S_ISSUE, S_WAIT: begin
                    r_tcnt <= r_tcnt + 1'b1;
                    if (r_state == S_WAIT && i_mem_valid) begin
                        r_rdata <= r_wen ? 32'h0 : i_mem_rdata;
                        r_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Counts data grants that bypassed a waiting fetch.
    always_ff @(posedge i_clk) begin
        if (i_rst)          r_starve <= '0;
        else if (w_grant_i) r_starve <= '0;
        else if (w_grant_d) begin
            if (!i_imem_req)     r_starve <= '0;
            else if (!w_starved) r_starve <= r_starve + 1'b1;
        end
    end

    always_comb begin
        o_imem_ready = 1'b0;
        o_dmem_ready = 1'b0;
        o_imem_valid = 1'b0;
        o_imem_rdata = '0;
        o_imem_err   = 1'b0;
        o_dmem_valid = 1'b0;
        o_dmem_rdata = '0;
        o_dmem_err   = 1'b0;
        o_mem_addr   = '0;
        o_mem_ren    = 1'b0;
        o_mem_wen    = 1'b0;
        o_mem_wdata  = '0;
        o_mem_mask   = '0;
        if (!i_rst) begin
            case (r_state)
                S_IDLE: begin
                    o_imem_ready = w_grant_i;
                    o_dmem_ready = w_grant_d;
                end
                S_ISSUE: begin
                    o_mem_addr  = r_addr;
                    o_mem_ren   = ~r_wen;
                    o_mem_wen   = r_wen;
                    o_mem_wdata = r_wdata;
                    o_mem_mask  = r_mask;
                end
                S_RESP: begin
                    if (r_owner_d) begin
                        o_dmem_valid = 1'b1;
                        o_dmem_rdata = r_rdata;
                        o_dmem_err   = r_err;
                    end else begin
                        o_imem_valid = 1'b1;
                        o_imem_rdata = r_rdata;
                        o_imem_err   = r_err;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;
    localparam int SL = 4;
    localparam int TO = 8;

    logic        i_clk, i_rst;
    logic        i_imem_req, o_imem_ready, o_imem_valid, o_imem_err;
    logic [31:0] i_imem_addr, o_imem_rdata;
    logic        i_dmem_req, i_dmem_wen, o_dmem_ready, o_dmem_valid, o_dmem_err;
    logic [31:0] i_dmem_addr, i_dmem_wdata, o_dmem_rdata;
    logic [3:0]  i_dmem_mask, o_mem_mask;
    logic [31:0] o_mem_addr, o_mem_wdata, i_mem_rdata;
    logic        o_mem_ren, o_mem_wen, i_mem_ready, i_mem_valid;

    mem_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_imem_req(i_imem_req), .i_imem_addr(i_imem_addr), .o_imem_ready(o_imem_ready),
        .o_imem_valid(o_imem_valid), .o_imem_rdata(o_imem_rdata), .o_imem_err(o_imem_err),
        .i_dmem_req(i_dmem_req), .i_dmem_addr(i_dmem_addr), .i_dmem_wen(i_dmem_wen),
        .i_dmem_wdata(i_dmem_wdata), .i_dmem_mask(i_dmem_mask), .o_dmem_ready(o_dmem_ready),
        .o_dmem_valid(o_dmem_valid), .o_dmem_rdata(o_dmem_rdata), .o_dmem_err(o_dmem_err),
        .o_mem_addr(o_mem_addr), .o_mem_ren(o_mem_ren), .o_mem_wen(o_mem_wen),
        .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
        .i_mem_ready(i_mem_ready), .i_mem_valid(i_mem_valid), .i_mem_rdata(i_mem_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        bit dreq; logic [31:0] addr; bit wen; logic [31:0] wdata; logic [3:0] mask;
        int rw; int vd; logic [31:0] mrdata;
        logic [31:0] e_maddr; bit e_ren; logic [3:0] e_mask; int e_strobes;
        logic [31:0] e_rdata; bit e_err; int e_lat;
    } vec_t;

    int cyc, checks, errors;
    // requester agents
    bit ipend, dpend, auto_i, auto_d, gen_on, model_on, rst_drv, dwen;
    logic [31:0] ia, da, dwd;
    logic [3:0]  dmask;
    // memory responder
    bit inj_valid, use_hash;
    logic [31:0] tbl_rdata, resp_data;
    int rdy_wait, val_delay, rdy_cnt, val_cnt;
    // monitor
    bit g_seen, g_d, s_first, s_new, s_ren, s_wen, r_seen, r_d, r_err;
    int g_cyc, r_cyc, n_ren, n_wen, n_both, n_ready, n_valid;
    logic [31:0] s_addr, s_wdata, r_data;
    logic [3:0]  s_mask;
    bit g_log[$];
    // reference model
    bit m_busy, e_d, e_wen;
    int m_starve;
    logic [31:0] e_addr, e_wdata, e_data;
    logic [3:0]  e_mask;

    function automatic logic [31:0] hashf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic bit any_out();
        return |{o_imem_ready, o_imem_valid, o_imem_rdata, o_imem_err,
                 o_dmem_ready, o_dmem_valid, o_dmem_rdata, o_dmem_err,
                 o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata, o_mem_mask};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit xi, xd;
        xi = 1'b0; xd = 1'b0;
        if (!m_busy) begin
            xd = i_dmem_req && !(i_imem_req && m_starve == SL);
            xi = i_imem_req && !xd;
        end
        if (i_imem_req || i_dmem_req || o_imem_ready || o_dmem_ready)
            chk("rand_grant", 32'({o_imem_ready, o_dmem_ready}), 32'({xi, xd}));
        if (xi || xd) begin
            if (xd) m_starve = i_imem_req ? ((m_starve < SL) ? m_starve + 1 : SL) : 0;
            else    m_starve = 0;
            m_busy  = 1'b1;
            e_d     = xd;
            e_wen   = xd && i_dmem_wen;
            e_addr  = (xd ? i_dmem_addr : i_imem_addr) & 32'hFFFF_FFFC;
            e_wdata = i_dmem_wdata;
            e_mask  = xd ? i_dmem_mask : 4'hF;
            e_data  = e_wen ? 32'h0 : hashf(e_addr);
        end
        if (s_new) begin
            s_new = 1'b0;
            chk("rand_mem_addr", s_addr, e_addr);
            chk("rand_mem_rw", 32'({s_ren, s_wen}), 32'({!e_wen, e_wen}));
            chk("rand_mem_mask", 32'(s_mask), 32'(e_mask));
            if (e_wen) chk("rand_mem_wdata", s_wdata, e_wdata);
        end
        if (o_imem_valid || o_dmem_valid) begin
            chk("rand_resp_busy", 32'(m_busy), 32'd1);
            chk("rand_resp_owner", 32'({o_imem_valid, o_dmem_valid}), 32'({!e_d, e_d}));
            chk("rand_resp_rdata", e_d ? o_dmem_rdata : o_imem_rdata, e_data);
            chk("rand_resp_err", 32'(o_imem_err | o_dmem_err), 32'd0);
            m_busy = 1'b0;
        end
    endtask

    // One clock: memory responder, requester drive, then sample after outputs settle.
    task automatic cycle();
        @(negedge i_clk);
        cyc++;
        i_mem_valid = 1'b0; i_mem_ready = 1'b0; i_mem_rdata = $urandom;
        if (inj_valid) begin i_mem_valid = 1'b1; inj_valid = 1'b0; end
        if (val_cnt > 0) begin
            val_cnt--;
            if (val_cnt == 0) begin i_mem_valid = 1'b1; i_mem_rdata = resp_data; end
        end
        if (o_mem_ren || o_mem_wen) begin
            if (s_first) begin
                s_first = 1'b0; s_new = 1'b1; rdy_cnt = rdy_wait;
                s_addr = o_mem_addr; s_wdata = o_mem_wdata; s_mask = o_mem_mask;
                s_ren = o_mem_ren; s_wen = o_mem_wen;
            end
            n_ren += int'(o_mem_ren); n_wen += int'(o_mem_wen);
            if (o_mem_ren && o_mem_wen) n_both++;
            if (rdy_cnt == 0) begin
                i_mem_ready = 1'b1;
                if (val_delay >= 0) val_cnt = val_delay + 1;
                resp_data = use_hash ? hashf(o_mem_addr) : tbl_rdata;
            end else rdy_cnt--;
        end
        if (auto_i) ipend = 1'b1;
        if (auto_d) dpend = 1'b1;
        if (gen_on) begin
            if (!ipend && $urandom_range(2) == 0) begin ipend = 1'b1; ia = $urandom; end
            if (!dpend && $urandom_range(2) == 0) begin
                dpend = 1'b1; da = $urandom; dwen = 1'($urandom); dwd = $urandom; dmask = 4'($urandom);
            end
        end
        i_rst        = rst_drv;
        i_imem_req   = ipend;
        i_imem_addr  = ipend ? ia : $urandom;
        i_dmem_req   = dpend;
        i_dmem_addr  = dpend ? da : $urandom;
        i_dmem_wen   = dpend ? dwen : 1'($urandom);
        i_dmem_wdata = dpend ? dwd : $urandom;
        i_dmem_mask  = dpend ? dmask : 4'($urandom);
        #1;
        if (o_imem_ready || o_dmem_ready) begin
            chk("single_ready", 32'(o_imem_ready & o_dmem_ready), 32'd0);
            g_seen = 1'b1; g_cyc = cyc; g_d = o_dmem_ready; g_log.push_back(o_dmem_ready);
            s_first = 1'b1; n_ready++;
            if (o_dmem_ready) dpend = 1'b0; else ipend = 1'b0;
            if (gen_on) begin rdy_wait = $urandom_range(2); val_delay = $urandom_range(3); end
        end
        if (o_imem_valid || o_dmem_valid) begin
            chk("single_valid", 32'(o_imem_valid & o_dmem_valid), 32'd0);
            r_seen = 1'b1; r_cyc = cyc; r_d = o_dmem_valid;
            r_data = o_dmem_valid ? o_dmem_rdata : o_imem_rdata;
            r_err  = o_dmem_valid ? o_dmem_err : o_imem_err;
            n_valid++;
        end
        if (model_on) model_step();
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string p;
        p = $sformatf("vec%0d", idx);
        use_hash = 1'b0; tbl_rdata = v.mrdata; rdy_wait = v.rw; val_delay = v.vd;
        g_seen = 1'b0; r_seen = 1'b0; n_ren = 0; n_wen = 0; n_both = 0;
        if (v.dreq) begin dpend = 1'b1; da = v.addr; dwen = v.wen; dwd = v.wdata; dmask = v.mask; end
        else begin ipend = 1'b1; ia = v.addr; end
        for (int k = 0; k < 40 && !r_seen; k++) cycle();
        chk({p, "_resp_seen"}, 32'(r_seen), 32'd1);
        chk({p, "_grant_owner"}, 32'(g_d), 32'(v.dreq));
        chk({p, "_resp_owner"}, 32'(r_d), 32'(v.dreq));
        chk({p, "_mem_addr"}, s_addr, v.e_maddr);
        chk({p, "_mem_ren"}, 32'(s_ren), 32'(v.e_ren));
        chk({p, "_mem_wen"}, 32'(s_wen), 32'(!v.e_ren));
        chk({p, "_mem_mask"}, 32'(s_mask), 32'(v.e_mask));
        if (v.dreq && v.wen) chk({p, "_mem_wdata"}, s_wdata, v.wdata);
        chk({p, "_ren_cycles"}, 32'(n_ren), 32'(v.e_ren ? v.e_strobes : 0));
        chk({p, "_wen_cycles"}, 32'(n_wen), 32'(v.e_ren ? 0 : v.e_strobes));
        chk({p, "_strobe_overlap"}, 32'(n_both), 32'd0);
        chk({p, "_rdata"}, r_data, v.e_rdata);
        chk({p, "_err"}, 32'(r_err), 32'(v.e_err));
        chk({p, "_latency"}, 32'(r_cyc - g_cyc), 32'(v.e_lat));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        int n0, rc;
        // dreq addr wen wdata mask | rw vd mrdata | maddr ren mask strobes rdata err lat
        tbl[0] = '{0, 32'h0000_0106, 0, 32'h0, 4'h0, 0, 0, 32'h00A0_0093,
                   32'h0000_0104, 1, 4'hF, 1, 32'h00A0_0093, 0, 3};
        tbl[1] = '{1, 32'h0000_2000, 0, 32'h0, 4'hC, 1, 1, 32'h1234_5678,
                   32'h0000_2000, 1, 4'hC, 2, 32'h1234_5678, 0, 5};
        tbl[2] = '{1, 32'h0000_3000, 1, 32'hDEAD_BEEF, 4'h1, 3, 0, 32'hFFFF_FFFF,
                   32'h0000_3000, 0, 4'h1, 4, 32'h0, 0, 6};
        tbl[3] = '{1, 32'h0000_4003, 0, 32'h0, 4'h2, 0, 2, 32'h0BAD_C0DE,
                   32'h0000_4000, 1, 4'h2, 1, 32'h0BAD_C0DE, 0, 5};
        tbl[4] = '{1, 32'h0000_5000, 0, 32'h0, 4'hF, 0, -1, 32'h7777_7777,
                   32'h0000_5000, 1, 4'hF, 1, 32'h0, 1, 9};
        tbl[5] = '{0, 32'h0000_7FFE, 0, 32'h0, 4'h0, 99, 0, 32'h2222_2222,
                   32'h0000_7FFC, 1, 4'hF, 8, 32'h0, 1, 9};
        tbl[6] = '{1, 32'h0000_6004, 0, 32'h0, 4'h3, 3, 3, 32'hCAFE_F00D,
                   32'h0000_6004, 1, 4'h3, 4, 32'hCAFE_F00D, 0, 9};
        tbl[7] = '{1, 32'h0000_800A, 1, 32'h0102_0304, 4'h6, 2, -1, 32'h3333_3333,
                   32'h0000_8008, 0, 4'h6, 3, 32'h0, 1, 9};
        tbl[8] = '{1, 32'h0000_9000, 0, 32'h0, 4'hF, 3, 4, 32'h1111_1111,
                   32'h0000_9000, 1, 4'hF, 4, 32'h0, 1, 9};

        i_rst = 1'b1; i_imem_req = 1'b0; i_dmem_req = 1'b0; i_imem_addr = '0;
        i_dmem_addr = '0; i_dmem_wen = 1'b0; i_dmem_wdata = '0; i_dmem_mask = '0;
        i_mem_ready = 1'b0; i_mem_valid = 1'b0; i_mem_rdata = '0;
        rst_drv = 1'b1;
        cycle(); cycle();
        chk("reset_outputs", 32'(any_out()), 32'd0);
        rst_drv = 1'b0;
        cycle();
        chk("idle_outputs", 32'(any_out()), 32'd0);

        foreach (tbl[i]) run_vec(tbl[i], i);

        // i_mem_valid arriving while idle after a timeout must not produce a pulse
        run_vec(tbl[4], 4);
        n0 = n_valid; inj_valid = 1'b1;
        repeat (4) cycle();
        chk("late_valid_ignored", 32'(n_valid - n0), 32'd0);

        // Simultaneous requests: data first, fetch in the IDLE right after the data RESP
        g_log.delete(); use_hash = 1'b1; rdy_wait = 0; val_delay = 0;
        ipend = 1'b1; ia = 32'h0000_0100;
        dpend = 1'b1; da = 32'h0000_2000; dwen = 1'b0; dmask = 4'b1100;
        r_seen = 1'b0;
        for (int k = 0; k < 20 && !r_seen; k++) cycle();
        rc = r_cyc;
        chk("simul_first_is_dmem", 32'((g_log.size() > 0) ? g_log[0] : 1'b0), 32'd1);
        chk("simul_dmem_mask", 32'(s_mask), 32'hC);
        chk("simul_dmem_ren", 32'(s_ren), 32'd1);
        chk("simul_dmem_resp", 32'({r_seen, r_d}), 32'b11);
        r_seen = 1'b0; g_seen = 1'b0;
        for (int k = 0; k < 20 && !r_seen; k++) cycle();
        chk("simul_imem_grant_cycle", 32'(g_cyc - rc), 32'd1);
        chk("simul_imem_resp", 32'({r_seen, r_d}), 32'b10);
        chk("simul_imem_rdata", r_data, hashf(32'h0000_0100));

        // Starvation: both held high -> 4 data grants, 1 fetch grant, repeated
        g_log.delete(); auto_i = 1'b1; auto_d = 1'b1;
        ia = 32'h0000_0200; da = 32'h0000_A000; dwen = 1'b0; dmask = 4'hF;
        for (int k = 0; k < 200 && g_log.size() < 10; k++) cycle();
        auto_i = 1'b0; auto_d = 1'b0; ipend = 1'b0; dpend = 1'b0;
        repeat (8) cycle();
        chk("starve_grant_count", 32'(g_log.size()), 32'd10);
        for (int k = 0; k < 10 && k < g_log.size(); k++)
            chk($sformatf("starve_grant%0d", k), 32'(g_log[k]), 32'((k == 4 || k == 9) ? 0 : 1));

        // Reset during WAIT: drop silently, ignore the memory's late valid
        use_hash = 1'b1; rdy_wait = 0; val_delay = 2;
        dpend = 1'b1; da = 32'h0000_B000; dwen = 1'b0; dmask = 4'hF; g_seen = 1'b0;
        for (int k = 0; k < 20 && !g_seen; k++) cycle();
        cycle();
        rst_drv = 1'b1;
        cycle();
        chk("rst_wait_outputs", 32'(any_out()), 32'd0);
        rst_drv = 1'b0;
        n0 = n_valid;
        repeat (6) cycle();
        chk("rst_no_response", 32'(n_valid - n0), 32'd0);
        chk("rst_idle_outputs", 32'(any_out()), 32'd0);
        run_vec(tbl[1], 10);

        // Randomized traffic against the reference model
        rst_drv = 1'b1; val_cnt = 0; ipend = 1'b0; dpend = 1'b0;
        cycle();
        rst_drv = 1'b0;
        m_busy = 1'b0; m_starve = 0; s_new = 1'b0; use_hash = 1'b1;
        model_on = 1'b1; gen_on = 1'b1;
        repeat (2000) cycle();
        gen_on = 1'b0;
        for (int k = 0; k < 60 && (ipend || dpend || m_busy); k++) cycle();
        chk("rand_drain", 32'({ipend, dpend, m_busy}), 32'd0);
        model_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
